// File: rtl/hash_arbiter_if.sv
// ----------------------------------------------------------------------------
// hash_arbiter_if
// Purpose : bundles the handshake between the arbiter and the shared hash
//           core (start pulse, message-memory port and digest return).
// Signals : k_in_ready  - start pulse, arbiter -> core
//           k_mem_addr  - message-memory address, core -> arbiter
//           k_mem_din   - message-memory data, arbiter -> core
//           k_out       - 512-bit digest, core -> arbiter
//           k_out_ready - digest-valid flag, core -> arbiter
// Modports: master = arbiter side, slave = hash core side.
// ----------------------------------------------------------------------------
interface hash_arbiter_if #(
   parameter int AW    = 4,
   parameter int WIDTH = 80
);
   logic             k_in_ready;
   logic [AW-1:0]    k_mem_addr;
   logic [WIDTH-1:0] k_mem_din;
   logic [511:0]     k_out;
   logic             k_out_ready;

   modport master (
      output k_in_ready,
      output k_mem_din,
      input  k_mem_addr,
      input  k_out,
      input  k_out_ready
   );

   modport slave (
      input  k_in_ready,
      input  k_mem_din,
      output k_mem_addr,
      output k_out,
      output k_out_ready
   );
endinterface

// File: rtl/hash_arbiter.sv
// ----------------------------------------------------------------------------
// hash_arbiter
// Purpose : shares one hash core between two requesters. Requests are served
//           round-robin (requester 0 first after reset); the winner's message
//           memory is routed to the core, the core is started with a one-cycle
//           pulse, and the returned digest is registered before a one-cycle
//           done pulse is sent to the winner.
// Ports   : clk, rst_b         - clock, asynchronous active-low reset
//           req0, req1         - request levels
//           mem_din0, mem_din1 - message-memory read data per requester
//           mem_addr           - address broadcast to both memories
//           done0, done1       - completion pulses
//           digest             - digest of the most recent completed job
//           gnt                - current / last granted requester
//           busy               - high whenever the FSM is not idle
//           err                - one-cycle timeout pulse (with done)
//           core               - hash core handshake (hash_arbiter_if.master)
// Config  : define HASH_ARB_TIMEOUT_EN to enable the WAIT watchdog, which ends
//           a job after TIMEOUT cycles without k_out_ready. Without it, err
//           is tied low and the arbiter waits indefinitely for the core.
// ----------------------------------------------------------------------------
module hash_arbiter #(
   parameter int AW      = 4,
   parameter int WIDTH   = 80,
   parameter int TIMEOUT = 4096
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic             req0,
   input  logic             req1,
   input  logic [WIDTH-1:0] mem_din0,
   input  logic [WIDTH-1:0] mem_din1,
   output logic [AW-1:0]    mem_addr,
   output logic             done0,
   output logic             done1,
   output logic [511:0]     digest,
   output logic             gnt,
   output logic             busy,
   output logic             err,
   hash_arbiter_if.master   core
);

   typedef enum logic [1:0] {
      IDLE,
      START,
      WAIT,
      DONE
   } state_t;

   state_t       r_state;
   state_t       w_nextState;
   logic         r_gnt;
   logic         r_last;
   logic [511:0] r_digest;
   logic         w_grantNext;
   logic         w_timeoutHit;
   logic         w_timedOut;

   // The memory port is a pure pass-through: the core's address goes to both
   // memories and only the granted requester's data is returned to the core.
   assign mem_addr       = core.k_mem_addr;
   assign core.k_mem_din = r_gnt ? mem_din1 : mem_din0;
   assign digest         = r_digest;
   assign gnt            = r_gnt;

`ifdef HASH_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] r_waitCount;
   logic          r_timedOut;

   assign w_timeoutHit = (r_waitCount == CW'(TIMEOUT - 1));
   assign w_timedOut   = r_timedOut;

   // Watchdog: counts cycles spent in WAIT without a digest. On the last
   // permitted cycle the FSM is pushed to DONE and r_timedOut is set so err
   // rises together with the done pulse. A digest arriving on that same cycle
   // still wins and the job completes normally.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         r_waitCount <= '0;
         r_timedOut  <= 1'b0;
      end else begin
         r_timedOut <= (r_state == WAIT) && !core.k_out_ready && w_timeoutHit;
         if ((r_state == WAIT) && !core.k_out_ready && !w_timeoutHit) begin
            r_waitCount <= r_waitCount + CW'(1);
         end else begin
            r_waitCount <= '0;
         end
      end
   end
`else
   logic w_unusedTimeout;

   assign w_unusedTimeout = ^TIMEOUT;
   assign w_timeoutHit    = 1'b0;
   assign w_timedOut      = 1'b0;
`endif

   // State register. Reset drops straight back to IDLE even mid-job, which
   // also clears every state-decoded output without waiting for a clock.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state and output decode. Requests are only looked at in IDLE, so
   // a requester dropping its line mid-job cannot disturb the job. When both
   // request, the one not served last wins; r_last resets to 1 so that
   // requester 0 is served first.
   always_comb begin
      w_nextState     = r_state;
      w_grantNext     = r_gnt;
      core.k_in_ready = 1'b0;
      done0           = 1'b0;
      done1           = 1'b0;
      err             = 1'b0;
      busy            = (r_state != IDLE);
      case (r_state)
         IDLE: begin
            if (req0 || req1) begin
               w_nextState = START;
               if (req0 && req1) begin
                  w_grantNext = ~r_last;
               end else begin
                  w_grantNext = req1;
               end
            end
         end
         START: begin
            core.k_in_ready = 1'b1;
            w_nextState     = WAIT;
         end
         WAIT: begin
            if (core.k_out_ready || w_timeoutHit) begin
               w_nextState = DONE;
            end
         end
         DONE: begin
            done0       = ~r_gnt;
            done1       = r_gnt;
            err         = w_timedOut;
            w_nextState = IDLE;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Job bookkeeping: the grant is captured when leaving IDLE and held until
   // the next grant, the digest is captured only from a WAIT-state
   // k_out_ready, and the served requester is remembered when the job ends.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         r_gnt    <= 1'b0;
         r_last   <= 1'b1;
         r_digest <= '0;
      end else begin
         r_gnt <= w_grantNext;
         if ((r_state == WAIT) && core.k_out_ready) begin
            r_digest <= core.k_out;
         end
         if (r_state == DONE) begin
            r_last <= r_gnt;
         end
      end
   end

endmodule

// File: doc/hash_arbiter.md
HASH_ARBITER -- requirements
Module: hash_arbiter

Interface
REQ-001 SHALL have parameter AW, default 4: memory address width of the hash core's message port.
REQ-002 SHALL have parameter WIDTH, default 80: width of one message-memory word.
REQ-003 SHALL have parameter TIMEOUT, default 4096: watchdog limit in cycles; used only when HASH_ARB_TIMEOUT_EN is defined.
REQ-004 SHALL have port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_b, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have ports req0 and req1, input, 1 each: hash request level from requester 0 and requester 1.
REQ-007 SHALL have ports mem_din0 and mem_din1, input, WIDTH each: read data from each requester's message memory.
REQ-008 SHALL have port mem_addr, output, AW: address broadcast to both message memories.
REQ-009 SHALL have ports done0 and done1, output, 1 each: one-cycle completion pulse per requester.
REQ-010 SHALL have port digest, output, 512: registered digest of the most recent completed job.
REQ-011 SHALL have port gnt, output, 1: index of the current or last granted requester.
REQ-012 SHALL have port busy, output, 1: high whenever the state is not IDLE.
REQ-013 SHALL have port err, output, 1: one-cycle timeout pulse.
REQ-014 SHALL have port k_in_ready, output, 1: start pulse to the hash core.
REQ-015 SHALL have port k_mem_addr, input, AW: memory address driven by the core.
REQ-016 SHALL have port k_mem_din, output, WIDTH: memory data returned to the core.
REQ-017 SHALL have port k_out, input, 512: digest from the core.
REQ-018 SHALL have port k_out_ready, input, 1: digest-valid flag from the core.

Function
REQ-019 SHALL implement FSM states IDLE, START, WAIT and DONE.
REQ-020 SHALL, in IDLE with any req high, select one requester, register it in gnt and move to START; otherwise SHALL stay in IDLE.
REQ-021 SHALL arbitrate round-robin: if req0 and req1 are both high, SHALL grant the requester other than the last one served; SHALL serve requester 0 first after reset.
REQ-022 SHALL drive k_in_ready=1 only in START, for exactly one cycle, then SHALL enter WAIT.
REQ-023 SHALL, in WAIT with k_out_ready=1, load k_out into digest and enter DONE.
REQ-024 SHALL, in DONE, pulse done[gnt] for one cycle, record gnt as last-served, and return to IDLE.
REQ-025 SHALL give a latency from req sampled in IDLE at cycle 0 to k_in_ready at cycle 1; k_out_ready at cycle N SHALL produce a done pulse at cycle N+1.
REQ-026 SHALL make the earliest next grant at cycle N+2 when jobs run back to back.
REQ-027 SHALL drive mem_addr = k_mem_addr and k_mem_din = (gnt ? mem_din1 : mem_din0) combinationally.
REQ-028 SHALL hold gnt stable from START through DONE.
REQ-029 SHALL complete a granted job and still pulse done if its req drops mid-job; req changes SHALL be ignored outside IDLE.
REQ-030 SHALL ignore k_out_ready outside WAIT.
REQ-031 SHALL hold digest between completions.
REQ-032 SHALL never assert done0 and done1 in the same cycle.

Reset
REQ-033 SHALL, on rst_b=0 at any time including mid-job, immediately force: state IDLE, gnt=0, last-served=1, digest=0, done0=0, done1=0, err=0, busy=0, k_in_ready=0, timeout counter=0.
REQ-034 SHALL resume arbitration on the first clock edge after rst_b rises.

Configuration
REQ-035 SHALL, with HASH_ARB_TIMEOUT_EN defined, count cycles spent in WAIT; when the count reaches TIMEOUT without k_out_ready, SHALL enter DONE with digest unchanged, pulse err together with done[gnt], and clear the counter.
REQ-036 SHALL, with HASH_ARB_TIMEOUT_EN undefined, contain no counter, tie err to 0, and wait indefinitely in WAIT.

Verification
REQ-037 SHALL test: req0=1 alone, core returns k_out=512'hA5..A5 four cycles after k_in_ready -> k_in_ready at cycle 1, done0 pulse at cycle 6, digest=A5..A5, done1 never high.
REQ-038 SHALL test: req0 and req1 both held high for two jobs -> grants in order 0, 1; second k_in_ready no earlier than 2 cycles after first done.
REQ-039 SHALL test: gnt=1, k_mem_addr=3, mem_din1=80'h1234, mem_din0=80'hFFFF -> mem_addr=3 and k_mem_din=80'h1234 in the same cycle.
REQ-040 SHALL test: req1 dropped in the cycle after START -> job completes and done1 still pulses once.
REQ-041 SHALL test: rst_b=0 asserted in WAIT -> outputs return to reset values without waiting for a clock; a k_out_ready arriving afterwards causes no done pulse.
REQ-042 SHALL test, with HASH_ARB_TIMEOUT_EN and TIMEOUT=16: k_out_ready never asserted -> err and done0 pulse 16 cycles after entering WAIT, and digest keeps its prior value.
